// File: rtl/iob_uart_tx_core.sv
// iob_uart_tx_core: 8N1 serial transmit engine.
// A one-byte holding register sits in front of the shift register, so the CSR
// block can queue the next byte while the current frame is on the line.
// Back-to-back frames go out with no idle gap.
module iob_uart_tx_core #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cke_i,
  input  logic              softreset_i,
  input  logic              txen_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DATA_W-1:0] txdata_wdata_i,
  input  logic              txdata_wen_i,
  output logic              txdata_wready_o,
  output logic              txready_o,
  output logic              txd_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  baud_reg, baud_next;
  logic [DIV_W-1:0]  period_reg, period_next;
  logic [2:0]        bit_reg, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic              hold_full_reg, hold_full_next;
  logic              acc_reg, acc_next;
  logic              txd_reg, txd_next;

  logic              accept;
  logic              load;
  logic              period_end;
  logic [DIV_W-1:0]  div_sat;

  // acc_reg masks ready for one cycle after each accept, so a write strobe
  // held for two cycles by the CSR block commits only one byte.
  assign txdata_wready_o = ~hold_full_reg & ~acc_reg;
  assign txready_o       = txen_i & ~hold_full_reg;
  assign txd_o           = txd_reg;
  assign accept          = txdata_wen_i & txdata_wready_o;

  // A bit period below 2 cycles is not supported; clamp it.
  assign div_sat    = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
  assign period_end = (baud_reg == (period_reg - DIV_W'(1)));

  // Next-state logic: holding register, FSM sequencing and line value
  always_comb begin
    state_next     = state_reg;
    baud_next      = baud_reg;
    period_next    = period_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    acc_next       = accept;
    txd_next       = txd_reg;
    load           = 1'b0;

    if (accept) begin
      hold_next      = txdata_wdata_i;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        if (hold_full_reg && txen_i) load = 1'b1;
      end
      START: begin
        baud_next = baud_reg + DIV_W'(1);
        if (period_end) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = shift_reg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        baud_next = baud_reg + DIV_W'(1);
        if (period_end) begin
          baud_next = '0;
          if (bit_reg == 3'(DATA_W - 1)) begin
            txd_next   = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            txd_next   = shift_reg[1];
          end
        end
      end
      STOP: begin
        baud_next = baud_reg + DIV_W'(1);
        if (period_end) begin
          baud_next = '0;
          // A queued byte chains straight into the next start bit.
          if (hold_full_reg && txen_i) load = 1'b1;
          else                         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Load and accept are mutually exclusive: load needs hold full, accept
    // needs hold empty. The divisor is sampled only here, so mid-frame
    // changes apply to the following frame.
    if (load) begin
      shift_next     = hold_reg;
      hold_full_next = 1'b0;
      period_next    = div_sat;
      baud_next      = '0;
      txd_next       = 1'b0;
      state_next     = START;
    end
  end

  // State registers with clock enable and synchronous reset / softreset
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i || softreset_i) begin
        state_reg     <= IDLE;
        baud_reg      <= '0;
        period_reg    <= DIV_W'(2);
        bit_reg       <= '0;
        shift_reg     <= '0;
        hold_reg      <= '0;
        hold_full_reg <= 1'b0;
        acc_reg       <= 1'b0;
        txd_reg       <= 1'b1;
      end else begin
        state_reg     <= state_next;
        baud_reg      <= baud_next;
        period_reg    <= period_next;
        bit_reg       <= bit_next;
        shift_reg     <= shift_next;
        hold_reg      <= hold_next;
        hold_full_reg <= hold_full_next;
        acc_reg       <= acc_next;
        txd_reg       <= txd_next;
      end
    end
  end

endmodule

// File: tb/tb_iob_uart_tx_core.sv
// Bench for iob_uart_tx_core: a line monitor decodes frames cycle by cycle
// against a queue of expected {byte, period} entries pushed at write time.
`timescale 1ns/1ps
module tb_iob_uart_tx_core;

  logic        clk = 1'b0;
  logic        rst_n, cke, softreset, txen;
  logic [15:0] div;
  logic [7:0]  wdata;
  logic        wen;
  logic        wready, txready, txd;

  always #5 clk = ~clk;

  iob_uart_tx_core #(.DIV_W(16), .DATA_W(8)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .cke_i           (cke),
    .softreset_i     (softreset),
    .txen_i          (txen),
    .div_i           (div),
    .txdata_wdata_i  (wdata),
    .txdata_wen_i    (wen),
    .txdata_wready_o (wready),
    .txready_o       (txready),
    .txd_o           (txd)
  );

  typedef struct {
    logic [7:0] data;
    int         period;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          period;
  } vec_t;

  exp_t exp_q[$];
  int   start_cyc[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   frames_done = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: every cycle of a frame is compared to the ideal waveform
  bit         mon_active = 1'b0;
  bit         mon_unexp;
  exp_t       cur;
  int         mon_cnt, mon_err, mon_bi;
  logic [9:0] mon_pat, mon_seen;

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_err    = 0;
        mon_seen   = '0;
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          mon_unexp  = 1'b1;
          cur.data   = 8'h00;
          cur.period = 2;
        end else begin
          mon_unexp = 1'b0;
          cur       = exp_q.pop_front();
        end
        mon_pat = {1'b1, cur.data, 1'b0};
      end
      if (mon_active) begin
        mon_bi = mon_cnt / cur.period;
        if (txd !== mon_pat[mon_bi]) mon_err++;
        if ((mon_cnt % cur.period) == (cur.period / 2)) mon_seen[mon_bi] = txd;
        mon_cnt++;
        if (mon_cnt == 10 * cur.period) begin
          mon_active = 1'b0;
          frames_done++;
          n_vec++;
          if (mon_unexp) begin
            n_mis++;
            $display("FAIL unexpected_frame: frame seen at cycle %0d, required none", cyc);
          end else if (mon_err != 0) begin
            n_mis++;
            $display("FAIL frame: bits(start=LSB) actual=%b required=%b bad_cycles=%0d period=%0d",
                     mon_seen, mon_pat, mon_err, cur.period);
          end else begin
            $display("frame data=%h period=%0d ok at cycle %0d", cur.data, cur.period, cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Wait (bounded) for wready, then write one byte and queue its expected frame
  task automatic write_byte(input logic [7:0] b, input int per);
    int waited;
    waited = 0;
    while (wready !== 1'b1 && waited < 400) begin
      tick();
      waited++;
    end
    if (wready !== 1'b1) begin
      chk("wready_timeout", wready, 1);
    end else begin
      wdata = b;
      wen   = 1'b1;
      exp_q.push_back('{data: b, period: per});
      tick();
      wen = 1'b0;
      $display("write data=%h expected_period=%0d at cycle %0d", b, per, cyc);
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (frames_done < target && k < 600) begin
      tick();
      k++;
    end
    chk("frame_done_timeout", (frames_done >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   tgt;
    int   low;
    vt = '{'{8'hA5, 16'd4, 4}, '{8'h00, 16'd3, 3}, '{8'hFF, 16'd1, 2},
           '{8'h3C, 16'd5, 5}, '{8'h81, 16'd2, 2}, '{8'h7E, 16'd0, 2}};

    // Reset held 3 cycles with a write strobe active: nothing is accepted
    rst_n = 1'b0; cke = 1'b1; softreset = 1'b0; txen = 1'b1;
    div = 16'd4; wdata = 8'h55; wen = 1'b1;
    repeat (3) tick();
    chk("rst_txd", txd, 1);
    chk("rst_wready", wready, 1);
    chk("rst_txready", txready, 1);
    rst_n = 1'b1; wen = 1'b0; mon_en = 1'b1;
    repeat (30) tick();
    chk("post_rst_frames", frames_done, 0);
    chk("post_rst_txd", txd, 1);

    // Table: single frames from idle, with handshake and latency checks
    for (int i = 0; i < 6; i++) begin
      div = vt[i].div;
      tgt = frames_done + 1;
      write_byte(vt[i].data, vt[i].period);
      chk("acc_wready", wready, 0);
      chk("acc_txready", txready, 0);
      chk("acc_txd_idle", txd, 1);
      tick();
      chk("lat_txd_start", txd, 0);
      chk("lat_wready", wready, 1);
      wait_done(tgt);
    end

    // Back-to-back frames: second start bit directly follows first stop bit
    div = 16'd3;
    start_cyc.delete();
    tgt = frames_done + 2;
    write_byte(8'h00, 3);
    write_byte(8'hFF, 3);
    chk("b2b_wready_full", wready, 0);
    chk("b2b_txready_full", txready, 0);
    repeat (10) tick();
    chk("b2b_wready_mid", wready, 0);
    chk("b2b_txready_mid", txready, 0);
    wait_done(tgt);
    chk("b2b_starts", start_cyc.size(), 2);
    if (start_cyc.size() >= 2) chk("b2b_gap", start_cyc[1] - start_cyc[0], 30);

    // Write strobe held for two cycles commits one byte
    chk("hold2_wready", wready, 1);
    tgt   = frames_done + 1;
    wdata = 8'h3C;
    wen   = 1'b1;
    exp_q.push_back('{data: 8'h3C, period: 3});
    tick();
    tick();
    wen = 1'b0;
    wait_done(tgt);
    repeat (40) tick();
    chk("hold2_frames", frames_done, tgt);
    chk("hold2_txready", txready, 1);

    // Divisor change mid-frame applies to the queued frame; div=0 clamps to 2
    div = 16'd4;
    start_cyc.delete();
    tgt = frames_done + 2;
    write_byte(8'h96, 4);
    write_byte(8'h69, 8);
    repeat (8) tick();
    div = 16'd8;
    wait_done(tgt);
    if (start_cyc.size() >= 2) chk("div_chg_gap", start_cyc[1] - start_cyc[0], 40);
    else chk("div_chg_starts", start_cyc.size(), 2);
    div = 16'd0;
    tgt = frames_done + 1;
    write_byte(8'hC3, 2);
    wait_done(tgt);

    // txen low: byte retained, no frame until re-enabled
    txen = 1'b0;
    tgt  = frames_done;
    write_byte(8'h42, 2);
    repeat (30) tick();
    chk("txen_off_frames", frames_done, tgt);
    chk("txen_off_txready", txready, 0);
    chk("txen_off_wready", wready, 0);
    chk("txen_off_txd", txd, 1);
    txen = 1'b1;
    wait_done(tgt + 1);

    // Clock enable low: a write strobe is ignored
    cke = 1'b0; wdata = 8'h99; wen = 1'b1;
    tgt = frames_done;
    repeat (3) tick();
    wen = 1'b0; cke = 1'b1;
    repeat (30) tick();
    chk("cke_off_frames", frames_done, tgt);
    chk("cke_off_txready", txready, 1);

    // Softreset during DATA with a byte queued: abort and discard
    mon_en = 1'b0;
    div    = 16'd4;
    write_byte(8'h5A, 4);
    write_byte(8'h11, 4);
    repeat (10) tick();
    softreset = 1'b1;
    tick();
    softreset = 1'b0;
    chk("srst_txd", txd, 1);
    chk("srst_wready", wready, 1);
    chk("srst_txready", txready, 1);
    low = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (txd !== 1'b1) low++;
    end
    chk("srst_idle_low_cycles", low, 0);
    exp_q.delete();
    mon_en = 1'b1;
    div    = 16'd5;
    tgt    = frames_done + 1;
    write_byte(8'hE7, 5);
    wait_done(tgt);

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
